// File: rtl/cordic_pkg.sv
// Shared types for the CORDIC vertex scheduler: vertex and angle triples plus
// the frame-sequencing state encoding.
package cordic_pkg;

  localparam int COORD_W = 16;
  localparam int VERT_W  = 3 * COORD_W;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic signed [COORD_W-1:0] z;
  } vertex_t;

  typedef struct packed {
    logic signed [COORD_W-1:0] alpha;
    logic signed [COORD_W-1:0] beta;
    logic signed [COORD_W-1:0] gamma;
  } angles_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/vert_result_ctr.sv
// Result-side bookkeeping: in-flight vertex count, in-order result write
// pointer, and the sticky flag for rotator dones that match no issued vertex.
module vert_result_ctr
  import cordic_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_clear,
  input  logic                                i_issue,
  input  logic                                i_rot_done,
  input  vertex_t                             i_rot_res,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   o_inflight,
  output logic                                o_wr_en,
  output logic [ADDR_W-1:0]                   o_wr_addr,
  output vertex_t                             o_wr_data,
  output logic                                o_err
);

  localparam int IF_W = $clog2(MAX_INFLIGHT + 1);

  logic [IF_W-1:0]   r_inflight;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_ptr;
  vertex_t           r_wr_data;
  logic              r_err;

  logic w_accept;
  logic w_spurious;

  assign w_accept   = i_rot_done && (r_inflight != '0);
  assign w_spurious = i_rot_done && (r_inflight == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
      r_wr_en    <= 1'b0;
      r_wr_ptr   <= '0;
      r_wr_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_data <= i_rot_res;
      end

      // write address advances after the write cycle, so address k holds result k
      if (i_clear) begin
        r_wr_ptr <= '0;
      end else if (r_wr_en) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end

      if (w_spurious) begin
        r_err <= 1'b1;
      end else if (i_clear) begin
        r_err <= 1'b0;
      end

      if (i_issue && !w_accept) begin
        r_inflight <= r_inflight + IF_W'(1);
      end else if (!i_issue && w_accept) begin
        r_inflight <= r_inflight - IF_W'(1);
      end
    end
  end

  assign o_inflight = r_inflight;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_ptr;
  assign o_wr_data  = r_wr_data;
  assign o_err      = r_err;

endmodule

// File: rtl/cordic_vertex_sched.sv
// Frame scheduler: fetches vertices, issues them to the 3D CORDIC rotator with
// start spacing and an in-flight cap, and reports completion once drained.
//
//   state   | meaning
//   IDLE    | waiting for a frame request
//   FETCH   | vertex read strobe for rd_ptr
//   CAPTURE | read data into the issue holding register
//   ISSUE   | wait for spacing and an in-flight slot, then start the rotator
//   DRAIN   | all vertices issued, waiting for results to be written
//   DONE    | one-cycle frame completion
module cordic_vertex_sched
  import cordic_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int ISSUE_GAP    = 18,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iFrameStart,
  input  logic signed [15:0]  iAlpha,
  input  logic signed [15:0]  iBeta,
  input  logic signed [15:0]  iGamma,
  input  logic [ADDR_W:0]     iVertCount,
  output logic                oBusy,
  output logic                oFrameDone,
  output logic                oErr,
  output logic                oRdEn,
  output logic [ADDR_W-1:0]   oRdAddr,
  input  logic [47:0]         iRdData,
  output logic                oRotStart,
  output logic signed [15:0]  oRotAlpha,
  output logic signed [15:0]  oRotBeta,
  output logic signed [15:0]  oRotGamma,
  output logic signed [15:0]  oRotX,
  output logic signed [15:0]  oRotY,
  output logic signed [15:0]  oRotZ,
  input  logic                iRotDone,
  input  logic signed [15:0]  iRotX,
  input  logic signed [15:0]  iRotY,
  input  logic signed [15:0]  iRotZ,
  output logic                oWrEn,
  output logic [ADDR_W-1:0]   oWrAddr,
  output logic [47:0]         oWrData
);

  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam int IF_W  = $clog2(MAX_INFLIGHT + 1);

  sched_state_t      r_state;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [GAP_W-1:0]  r_gap;
  angles_t           r_ang;
  vertex_t           r_hold;

  logic [IF_W-1:0]   w_inflight;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  vertex_t           w_wr_data;
  logic              w_err;
  vertex_t           w_rot_res;
  logic              w_accept;
  logic              w_clear;
  logic              w_issue;
  logic [ADDR_W:0]   w_next_ptr;
  logic              w_last;

  assign w_accept   = (r_state == S_IDLE) && iFrameStart;
  assign w_clear    = w_accept && (iVertCount != '0);
  assign w_issue    = (r_state == S_ISSUE) && (r_gap == '0) &&
                      (w_inflight < IF_W'(MAX_INFLIGHT));
  assign w_next_ptr = {1'b0, r_rd_ptr} + (ADDR_W+1)'(1);
  assign w_last     = (w_next_ptr == r_count);
  assign w_rot_res  = '{x: iRotX, y: iRotY, z: iRotZ};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_rd_en      <= 1'b0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_gap        <= '0;
      r_ang        <= '0;
      r_hold       <= '0;
    end else begin
      r_frame_done <= 1'b0;
      r_rd_en      <= 1'b0;
      if (r_gap != '0) begin
        r_gap <= r_gap - GAP_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (iFrameStart) begin
            r_busy <= 1'b1;
            if (iVertCount != '0) begin
              r_ang    <= '{alpha: iAlpha, beta: iBeta, gamma: iGamma};
              r_count  <= iVertCount;
              r_rd_ptr <= '0;
              r_rd_en  <= 1'b1;
              r_state  <= S_FETCH;
            end else begin
              r_frame_done <= 1'b1;
              r_state      <= S_DONE;
            end
          end
        end
        S_FETCH: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_hold  <= vertex_t'(iRdData);
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_gap    <= GAP_W'(ISSUE_GAP - 1);
            if (w_last) begin
              r_state <= S_DRAIN;
            end else begin
              r_rd_en <= 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_DRAIN: begin
          // the final result write must also have left before completion
          if ((w_inflight == '0) && !w_wr_en) begin
            r_frame_done <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  vert_result_ctr #(
    .ADDR_W       (ADDR_W),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_result_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_clear),
    .i_issue    (w_issue),
    .i_rot_done (iRotDone),
    .i_rot_res  (w_rot_res),
    .o_inflight (w_inflight),
    .o_wr_en    (w_wr_en),
    .o_wr_addr  (w_wr_addr),
    .o_wr_data  (w_wr_data),
    .o_err      (w_err)
  );

  assign oBusy      = r_busy;
  assign oFrameDone = r_frame_done;
  assign oErr       = w_err;
  assign oRdEn      = r_rd_en;
  assign oRdAddr    = r_rd_ptr;
  assign oRotStart  = w_issue;
  assign oRotAlpha  = r_ang.alpha;
  assign oRotBeta   = r_ang.beta;
  assign oRotGamma  = r_ang.gamma;
  assign oRotX      = r_hold.x;
  assign oRotY      = r_hold.y;
  assign oRotZ      = r_hold.z;
  assign oWrEn      = w_wr_en;
  assign oWrAddr    = w_wr_addr;
  assign oWrData    = w_wr_data;

endmodule
